max_pool_2x2: RTL and testbench
===============================

Name: max_pool_2x2

Overview:
- 2x2, stride-2 max-pooling stage that sits directly downstream of the 3x3 convolution engine.
- Consumes the conv engine's raster-order FP32 output stream (one pixel per valid_in pulse) and emits one FP32 maximum per non-overlapping 2x2 window.
- Output is also raster order.
- Keeps one half-width row of partial maxima so the next conv layer or the flatten/FC stage sees a stream reduced by 4x.

Parameters:
- DATA_WIDTH, 32: sample width; IEEE-754 single precision.
- WIDTH_IMG, 26: pixels per input row (conv output width).
- HEIGHT_IMG, 26: rows per input frame.

Ports:
- clk  input  1  clock, rising edge.
- resetn  input  1  asynchronous, active-low reset.
- start  input  1  global enable; low freezes the block.
- valid_in  input  1  data_in carries a pixel this cycle.
- data_in  input  DATA_WIDTH  FP32 input pixel.
- valid_out  output  1  data_out carries a pooled result (one-cycle pulse per result).
- data_out  output  DATA_WIDTH  FP32 pooled maximum.
- frame_done  output  1  pulses together with the last pooled result of a frame.

Behaviour:
- Reset (resetn=0, asynchronous) clears the following:
  - valid_out=0, data_out=0, frame_done=0.
  - Column counter, row counter and pair-hold register cleared to 0.
  - Row buffer contents are don't-care; they are always written before being read.
- A pixel is accepted on a rising edge with start=1 and valid_in=1. valid_in is ignored while start=0.
- start=0:
  - Counters, hold register and row buffer keep their values.
  - valid_out and frame_done are forced to 0; data_out holds.
  - Processing resumes exactly where it stopped.
- Counters:
  - col counts 0..WIDTH_IMG-1 and wraps to 0 after the last column, incrementing row.
  - row counts 0..HEIGHT_IMG-1 and wraps to 0 after the last pixel of the frame.
  - Both advance only on accepted pixels; arbitrary bubbles between pixels are legal.
- Pooling region:
  - Only col < 2*floor(WIDTH_IMG/2) and row < 2*floor(HEIGHT_IMG/2) take part.
  - An odd trailing column or row is accepted (counters still advance) but discarded.
- Even col: store the pixel in the hold register.
- Odd col: pm = fpmax(hold, pixel).
  - On an even row, write pm to row_buf[col>>1]; there is no output.
  - On an odd row, register data_out = fpmax(row_buf[col>>1], pm) and pulse valid_out for one cycle.
- Latency: valid_out rises on the clock edge that accepts the bottom-right pixel of the window; the result is visible the cycle after that pixel is presented.
- Output count per frame is floor(WIDTH_IMG/2)*floor(HEIGHT_IMG/2).
- frame_done=1 in the same cycle as the valid_out of window (last row, last column).
- Row buffer depth is floor(WIDTH_IMG/2) entries of DATA_WIDTH bits. Registers or inferred RAM are both acceptable; read and write happen on the same edge.
- fpmax(a,b) is combinational on raw bits:
  - Signs differ: the positive operand wins.
  - Both positive: the larger {exp,mant} wins.
  - Both negative: the smaller {exp,mant} wins.
  - Tie, including +0 vs -0: a wins.
  - NaN and Inf are not produced upstream; behaviour on them is unspecified.
- Reset asserted mid-frame: the partial frame is discarded. The next accepted pixel is treated as (row 0, col 0).

Test Plan:
1. Reset: assert resetn=0 with random inputs -> valid_out=0, frame_done=0, data_out=0x00000000 throughout.
2. W=4, H=4, start=1, pixels 1.0..16.0 back-to-back -> exactly 4 pulses:
   - 0x40C00000 (6.0), 0x41000000 (8.0), 0x41600000 (14.0), 0x41800000 (16.0).
   - Each pulse follows the 6th, 8th, 14th and 16th accepted pixel; frame_done only with 16.0.
3. Sign handling:
   - W=H=2 window {-1.0, -2.0, -0.5, -3.0} -> 0xBF000000 (-0.5).
   - Window {-4.0, 0.25, -0.0, +0.0} -> 0x3E800000 (0.25).
   - Window {+0.0, -0.0, -0.0, -0.0} -> 0x00000000.
4. Bubbles and freeze:
   - Repeat scenario 2 with random valid_in gaps and start held low for 5 cycles mid-row-2 -> identical 4 results.
   - No valid_out while start=0; frame_done count = 1.
5. Odd dimensions: W=5, H=5, pixels 1.0..25.0 -> 4 outputs 7.0, 9.0, 17.0, 19.0. Column 5 and row 5 are dropped and no output is attributable to them.
6. Wrap and mid-frame reset:
   - Two back-to-back 4x4 frames -> 8 outputs, frame_done twice.
   - Reset after 7 pixels of a frame, then a full 4x4 frame -> only the 4 scenario-2 values.

Source files
------------

// File: rtl/max_pool_2x2.sv
// -----------------------------------------------------------------------------
// max_pool_2x2
//   2x2, stride-2 max pooling over a raster-order FP32 pixel stream.
//   Even columns are parked in a hold register, each horizontal pair maximum
//   of an even row is stored in a half-width row buffer, and on the odd row
//   the pair maximum is merged with the stored one to produce the result.
//   An odd trailing column/row is consumed (counters advance) but ignored.
//
// Ports
//   clk         in   rising-edge clock
//   resetn      in   asynchronous active-low reset
//   start       in   global enable; low freezes all state, suppresses pulses
//   valid_in    in   data_in carries a pixel this cycle
//   data_in     in   FP32 input pixel
//   valid_out   out  one-cycle pulse per pooled result
//   data_out    out  FP32 pooled maximum (holds between results)
//   frame_done  out  pulses with the last pooled result of a frame
// -----------------------------------------------------------------------------
module max_pool_2x2 #(
  parameter int DATA_WIDTH = 32,
  parameter int WIDTH_IMG  = 26,
  parameter int HEIGHT_IMG = 26
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  frame_done
);

  localparam int POOL_W = WIDTH_IMG / 2;
  localparam int POOL_H = HEIGHT_IMG / 2;
  localparam int COL_W  = (WIDTH_IMG  > 1) ? $clog2(WIDTH_IMG)  : 1;
  localparam int ROW_W  = (HEIGHT_IMG > 1) ? $clog2(HEIGHT_IMG) : 1;
  localparam int IDX_W  = (POOL_W     > 1) ? $clog2(POOL_W)     : 1;

  localparam logic [COL_W-1:0] COL_LAST      = COL_W'(WIDTH_IMG - 1);
  localparam logic [ROW_W-1:0] ROW_LAST      = ROW_W'(HEIGHT_IMG - 1);
  localparam logic [COL_W-1:0] POOL_COL_LAST = COL_W'(2 * POOL_W - 1);
  localparam logic [ROW_W-1:0] POOL_ROW_LAST = ROW_W'(2 * POOL_H - 1);
  localparam bit               ODD_W         = (WIDTH_IMG  % 2) != 0;
  localparam bit               ODD_H         = (HEIGHT_IMG % 2) != 0;

  // Sign-magnitude compare on raw bits. Any pair of zeros is a tie, so
  // +0 vs -0 keeps operand a; ties always keep a.
  function automatic logic [DATA_WIDTH-1:0] fpmax(
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
    logic                  a_sign;
    logic                  b_sign;
    logic [DATA_WIDTH-2:0] a_mag;
    logic [DATA_WIDTH-2:0] b_mag;
    logic                  a_wins;
    a_sign = a[DATA_WIDTH-1];
    b_sign = b[DATA_WIDTH-1];
    a_mag  = a[DATA_WIDTH-2:0];
    b_mag  = b[DATA_WIDTH-2:0];
    if (a_mag == '0 && b_mag == '0) a_wins = 1'b1;
    else if (a_sign != b_sign)      a_wins = ~a_sign;
    else if (!a_sign)               a_wins = (a_mag >= b_mag);
    else                            a_wins = (a_mag <= b_mag);
    return a_wins ? a : b;
  endfunction

  logic [COL_W-1:0]      r_col;
  logic [ROW_W-1:0]      r_row;
  logic [DATA_WIDTH-1:0] r_hold;
  logic [DATA_WIDTH-1:0] r_row_buf [POOL_W];

  logic                  w_accept;
  logic                  w_in_region;
  logic                  w_buf_we;
  logic                  w_last_window;
  logic [IDX_W-1:0]      w_rb_idx;
  logic [DATA_WIDTH-1:0] w_pm;
  logic [DATA_WIDTH-1:0] w_pool;

  always_comb begin
    w_accept      = start & valid_in;
    // Only the trailing column/row of an odd dimension falls outside.
    w_in_region   = (!ODD_W || (r_col != COL_LAST)) &&
                    (!ODD_H || (r_row != ROW_LAST));
    w_rb_idx      = IDX_W'(r_col >> 1);
    w_pm          = fpmax(r_hold, data_in);
    w_pool        = fpmax(r_row_buf[w_rb_idx], w_pm);
    w_buf_we      = w_accept & w_in_region & r_col[0] & ~r_row[0];
    w_last_window = (r_row == POOL_ROW_LAST) && (r_col == POOL_COL_LAST);
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_col      <= '0;
      r_row      <= '0;
      r_hold     <= '0;
      valid_out  <= 1'b0;
      data_out   <= '0;
      frame_done <= 1'b0;
    end else begin
      // Pulses default low every cycle, which also covers start=0.
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      if (w_accept) begin
        if (r_col == COL_LAST) begin
          r_col <= '0;
          r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end

        if (w_in_region) begin
          if (!r_col[0]) begin
            r_hold <= data_in;
          end else if (r_row[0]) begin
            data_out   <= w_pool;
            valid_out  <= 1'b1;
            frame_done <= w_last_window;
          end
        end
      end
    end
  end

  // NOTE: the row buffer has no reset; each entry is written on an even row
  // before the odd row reads it, so reset would only add fan-out.
  always_ff @(posedge clk) begin
    if (w_buf_we) r_row_buf[w_rb_idx] <= w_pm;
  end

endmodule

// File: tb/tb_max_pool_2x2.sv
// -----------------------------------------------------------------------------
// tb_max_pool_2x2
//   Self-checking bench for max_pool_2x2. Three instances (4x4, 2x2, 5x5)
//   share one input stream; each scenario checks the instance(s) it targets.
//   Expected values come from hand constants, a window table, and a
//   stream-level pooling model (window max by signed-value comparison).
// -----------------------------------------------------------------------------
module tb_max_pool_2x2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic        valid_in;
  logic [31:0] data_in;

  logic        vo4, fd4, vo2, fd2, vo5, fd5;
  logic [31:0] do4, do2, do5;

  int n_checks = 0;
  int n_fail   = 0;

  max_pool_2x2 #(.DATA_WIDTH(32), .WIDTH_IMG(4), .HEIGHT_IMG(4)) u_dut4 (
    .clk(clk), .resetn(resetn), .start(start), .valid_in(valid_in),
    .data_in(data_in), .valid_out(vo4), .data_out(do4), .frame_done(fd4));

  max_pool_2x2 #(.DATA_WIDTH(32), .WIDTH_IMG(2), .HEIGHT_IMG(2)) u_dut2 (
    .clk(clk), .resetn(resetn), .start(start), .valid_in(valid_in),
    .data_in(data_in), .valid_out(vo2), .data_out(do2), .frame_done(fd2));

  max_pool_2x2 #(.DATA_WIDTH(32), .WIDTH_IMG(5), .HEIGHT_IMG(5)) u_dut5 (
    .clk(clk), .resetn(resetn), .start(start), .valid_in(valid_in),
    .data_in(data_in), .valid_out(vo5), .data_out(do5), .frame_done(fd5));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, expv);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint fkey(input logic [31:0] b);
    longint m;
    m = 0;
    m[30:0] = b[30:0];
    return b[31] ? -m : m;
  endfunction

  // First occurrence (raster order) of the largest value in the window.
  function automatic logic [31:0] win_max(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] c, input logic [31:0] d);
    logic [31:0] v [4];
    logic [31:0] best;
    v = '{a, b, c, d};
    best = v[0];
    for (int i = 1; i < 4; i++) if (fkey(v[i]) > fkey(best)) best = v[i];
    return best;
  endfunction

  function automatic logic [31:0] fp(input int n);
    int          e;
    logic [31:0] r;
    e = 0;
    for (int i = 0; i < 24; i++) if (((n >> i) & 1) == 1) e = i;
    r[31]    = 1'b0;
    r[30:23] = 8'(127 + e);
    r[22:0]  = 23'(n << (23 - e));
    return r;
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] r;
    r = $urandom;
    if (r[30:23] == 8'hFF) r[30:23] = 8'hFE;
    if ($urandom_range(0, 7) == 0) r = {1'($urandom_range(0, 1)), 31'd0};
    return r;
  endfunction

  logic [31:0] pix_q [$];
  logic [31:0] exp_q [$];
  int          exp_fd;

  // Every window whose bottom-right pixel exists in pix_q yields one result.
  task automatic run_model(input int w, input int h);
    int fsz;
    exp_q.delete();
    exp_fd = 0;
    fsz = w * h;
    for (int f = 0; f * fsz < pix_q.size(); f++)
      for (int wr = 0; wr < h / 2; wr++)
        for (int wc = 0; wc < w / 2; wc++) begin
          int tl;
          tl = f * fsz + 2 * wr * w + 2 * wc;
          if (tl + w + 1 < pix_q.size()) begin
            exp_q.push_back(win_max(pix_q[tl], pix_q[tl+1], pix_q[tl+w], pix_q[tl+w+1]));
            if (wr == h / 2 - 1 && wc == w / 2 - 1) exp_fd++;
          end
        end
  endtask

  // ---------------- output monitor ----------------
  bit          mon_en = 1'b0;
  bit          start_q = 1'b0;
  logic [31:0] q4 [$], q2 [$], q5 [$];
  int          fd4_n, fd2_n, fd5_n, freeze_viol;

  always @(posedge clk) start_q <= start;

  always @(negedge clk) begin
    if (mon_en) begin
      if (vo4) q4.push_back(do4);
      if (vo2) q2.push_back(do2);
      if (vo5) q5.push_back(do5);
      if (fd4) fd4_n++;
      if (fd2) fd2_n++;
      if (fd5) fd5_n++;
      if ((vo4 || vo2 || vo5) && !start_q) freeze_viol++;
    end
  end

  task automatic mon_clear();
    q4.delete(); q2.delete(); q5.delete();
    fd4_n = 0; fd2_n = 0; fd5_n = 0; freeze_viol = 0;
  endtask

  task automatic compare_out(input string name, input logic [31:0] act [$], input int act_fd);
    check({name, "_count"}, 32'(act.size()), 32'(exp_q.size()));
    for (int i = 0; i < act.size() && i < exp_q.size(); i++)
      check($sformatf("%s_val%0d", name, i), act[i], exp_q[i]);
    check({name, "_frame_done"}, 32'(act_fd), 32'(exp_fd));
  endtask

  // ---------------- stimulus ----------------
  task automatic push(input logic [31:0] p);
    @(negedge clk);
    start = 1'b1; valid_in = 1'b1; data_in = p;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid_in = 1'b0; data_in = $urandom;
    end
  endtask

  task automatic freeze(input int n);
    repeat (n) begin
      @(negedge clk);
      start = 1'b0; valid_in = 1'($urandom); data_in = $urandom;
    end
  endtask

  task automatic push_gap(input logic [31:0] p);
    if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    push(p);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0; start = 1'($urandom); valid_in = 1'($urandom); data_in = $urandom;
    repeat (2) @(negedge clk);
    resetn = 1'b1; valid_in = 1'b0;
  endtask

  typedef struct {
    logic [31:0] px [4];
    logic [31:0] expv;
  } win_vec_t;

  win_vec_t    win_tbl [6];
  logic [31:0] s2_exp  [4];

  initial begin
    win_tbl[0].px = '{32'hBF800000, 32'hC0000000, 32'hBF000000, 32'hC0400000}; // -1,-2,-0.5,-3
    win_tbl[0].expv = 32'hBF000000;
    win_tbl[1].px = '{32'hC0800000, 32'h3E800000, 32'h80000000, 32'h00000000}; // -4,0.25,-0,+0
    win_tbl[1].expv = 32'h3E800000;
    win_tbl[2].px = '{32'h00000000, 32'h80000000, 32'h80000000, 32'h80000000}; // +0,-0,-0,-0
    win_tbl[2].expv = 32'h00000000;
    win_tbl[3].px = '{32'h80000000, 32'h00000000, 32'h80000000, 32'h00000000}; // zero tie keeps first
    win_tbl[3].expv = 32'h80000000;
    win_tbl[4].px = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h3FC00000}; // 1,2,3,1.5
    win_tbl[4].expv = 32'h40400000;
    win_tbl[5].px = '{32'hC1200000, 32'h3F800000, 32'hBF800000, 32'h3F000000}; // -10,1,-1,0.5
    win_tbl[5].expv = 32'h3F800000;
    s2_exp = '{32'h40C00000, 32'h41000000, 32'h41600000, 32'h41800000};

    resetn = 1'b0; start = 1'b0; valid_in = 1'b0; data_in = '0;
    mon_clear();

    // 1. Reset with random inputs.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      start = 1'($urandom); valid_in = 1'($urandom); data_in = $urandom;
      check($sformatf("reset_valid_%0d", i), 32'(vo4), 32'd0);
      check($sformatf("reset_data_%0d", i), do4, 32'd0);
      check($sformatf("reset_fdone_%0d", i), 32'(fd4), 32'd0);
    end
    check("reset_others", {do2, do5}, 32'd0);
    check("reset_others_flags", 32'({vo2, fd2, vo5, fd5}), 32'd0);
    @(negedge clk);
    resetn = 1'b1; valid_in = 1'b0;

    // 2. 4x4 frame 1.0..16.0 back-to-back, cycle-exact latency.
    begin
      int oi;
      oi = 0;
      for (int k = 1; k <= 16; k++) begin
        bit ev;
        push(fp(k));
        ev = (k == 6 || k == 8 || k == 14 || k == 16);
        check($sformatf("s2_valid_px%0d", k), 32'(vo4), 32'(ev));
        check($sformatf("s2_fdone_px%0d", k), 32'(fd4), 32'(k == 16));
        if (ev) begin
          check($sformatf("s2_data_px%0d", k), do4, s2_exp[oi]);
          oi++;
        end
      end
      idle(1);
      @(posedge clk); #1;
      check("s2_pulse_one_cycle", 32'(vo4), 32'd0);
      check("s2_data_holds", do4, 32'h41800000);
    end

    // 3. Sign handling, table of 2x2 windows.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 4; j++) push(win_tbl[i].px[j]);
      check($sformatf("win%0d_valid", i), 32'(vo2), 32'd1);
      check($sformatf("win%0d_data", i), do2, win_tbl[i].expv);
      check($sformatf("win%0d_fdone", i), 32'(fd2), 32'd1);
    end
    idle(2);

    // 4. Bubbles and a freeze mid row 2.
    do_reset();
    mon_clear();
    mon_en = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      push_gap(fp(k));
      if (k == 10) freeze(5);
    end
    idle(3);
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(s2_exp[i]);
    exp_fd = 1;
    compare_out("s4", q4, fd4_n);
    check("s4_no_out_while_frozen", 32'(freeze_viol), 32'd0);

    // 5. Odd dimensions, 5x5 frame 1.0..25.0.
    do_reset();
    mon_clear();
    for (int k = 1; k <= 25; k++) push(fp(k));
    idle(3);
    exp_q = '{fp(7), fp(9), fp(17), fp(19)};
    exp_fd = 1;
    compare_out("s5", q5, fd5_n);

    // 6a. Two back-to-back 4x4 frames (second one random).
    do_reset();
    mon_clear();
    pix_q.delete();
    for (int k = 1; k <= 16; k++) pix_q.push_back(fp(k));
    for (int k = 0; k < 16; k++) pix_q.push_back(rand_fp());
    foreach (pix_q[i]) push(pix_q[i]);
    idle(3);
    run_model(4, 4);
    compare_out("s6_wrap", q4, fd4_n);

    // 6b. Reset after 7 pixels, then a clean frame.
    do_reset();
    for (int k = 0; k < 7; k++) push(rand_fp());
    do_reset();
    mon_clear();
    for (int k = 1; k <= 16; k++) push(fp(k));
    idle(3);
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(s2_exp[i]);
    exp_fd = 1;
    compare_out("s6_midreset", q4, fd4_n);

    // 7. Random stream with gaps and freezes into all three geometries.
    do_reset();
    mon_clear();
    pix_q.delete();
    for (int k = 0; k < 100; k++) begin
      logic [31:0] p;
      p = ($urandom_range(0, 5) == 0 && pix_q.size() > 0) ? pix_q[pix_q.size()-1] : rand_fp();
      pix_q.push_back(p);
    end
    foreach (pix_q[i]) begin
      push_gap(pix_q[i]);
      if ($urandom_range(0, 15) == 0) freeze($urandom_range(1, 4));
    end
    idle(3);
    run_model(4, 4);
    compare_out("rnd4", q4, fd4_n);
    run_model(2, 2);
    compare_out("rnd2", q2, fd2_n);
    run_model(5, 5);
    compare_out("rnd5", q5, fd5_n);
    check("rnd_no_out_while_frozen", 32'(freeze_viol), 32'd0);
    mon_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
